step_dispatch: RTL

- Execute-stage sequencer that launches one step module (clear, move, ALU op, and so on) per instruction.
- Decodes the opcode and pulses that step's active-low enable.
- Waits on the shared wired-low step-ready line, then reports completion upstream on its own open-drain rdy_.
- Guards against hung or missing steps with a watchdog and a sticky fault flag.

---
 rtl/step_dispatch_pkg.sv | 32 +++
 rtl/step_decode.sv | 20 ++
 rtl/step_dispatch.sv | 108 ++++++++++
 3 files changed

// File: rtl/step_dispatch_pkg.sv
// Shared types and opcode field layout for the execute-stage step sequencer.
package step_dispatch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE,
      FAULT
   } state_t;

   localparam int IDX_LSB = 0;
   localparam int OPW_MAX = 64;

   function automatic int idx_width(input int n_steps);
      return $clog2(n_steps);
   endfunction

   // Bits above the index field must be zero for a legal opcode.
   function automatic logic [OPW_MAX-1:0] legal_mask(
      input int opw,
      input int iw
   );
      logic [OPW_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < OPW_MAX; i++) begin
         if (i >= IDX_LSB + iw && i < opw) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/step_decode.sv
// Opcode to step index decode with legality check.
module step_decode
   import step_dispatch_pkg::*;
#(
   parameter int N_STEPS = 8,
   parameter int OPW     = 8,
   parameter int IW      = 3
) (
   input  logic [OPW-1:0] opcode,
   output logic [IW-1:0]  idx,
   output logic           legal
);

   localparam logic [OPW_MAX-1:0] MASK_W = legal_mask(OPW, IW);
   localparam logic [OPW-1:0] MASK = MASK_W[OPW-1:0];

   assign idx   = opcode[IDX_LSB +: IW];
   assign legal = ~|(opcode & MASK);

endmodule

// File: rtl/step_dispatch.sv
// Execute-stage sequencer: launch one step, await the shared ready,
// report completion upstream, watchdog hung steps.
module step_dispatch
   import step_dispatch_pkg::*;
#(
   parameter int N_STEPS = 8,
   parameter int OPW     = 8,
   parameter int TIMEOUT = 15
) (
   input  logic               clk,
   input  logic               rst_,
   input  logic               ena_,
   input  logic [OPW-1:0]     opcode,
   output logic               rdy_,
   output logic [N_STEPS-1:0] step_ena_,
   input  logic               step_rdy_,
   output logic               busy,
   output logic               fault
);

   localparam int IW = idx_width(N_STEPS);
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
   localparam logic [N_STEPS-1:0] ONE = N_STEPS'(1);

   state_t             state;
   logic [TW-1:0]      timer;
   logic               rdy_q;
   logic [N_STEPS-1:0] step_ena_q;
   logic               busy_q;
   logic               fault_q;
   logic [IW-1:0]      idx;
   logic               legal;
   logic               ready;

   step_decode #(
      .N_STEPS (N_STEPS),
      .OPW     (OPW),
      .IW      (IW)
   ) u_decode (
      .opcode (opcode),
      .idx    (idx),
      .legal  (legal)
   );

   // Only a driven 0 counts as ready; Z or X fall through as not ready.
   assign ready = (step_rdy_ === 1'b0);

   always_ff @(posedge clk) begin
      if (!rst_) begin
         state      <= IDLE;
         timer      <= '0;
         rdy_q      <= 1'b0;
         step_ena_q <= '1;
         busy_q     <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (!ena_ && legal) begin
                  state      <= ISSUE;
                  step_ena_q <= ~(ONE << idx);
                  busy_q     <= 1'b1;
               end else if (!ena_) begin
                  state   <= FAULT;
                  rdy_q   <= 1'b1;
                  fault_q <= 1'b1;
                  busy_q  <= 1'b1;
               end
            end
            ISSUE: begin
               state      <= WAIT;
               step_ena_q <= '1;
               timer      <= '0;
            end
            WAIT: begin
               if (ready) begin
                  state <= DONE;
                  rdy_q <= 1'b1;
               end else if (timer == T_LAST) begin
                  state   <= FAULT;
                  rdy_q   <= 1'b1;
                  fault_q <= 1'b1;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            DONE, FAULT: begin
               state  <= IDLE;
               rdy_q  <= 1'b0;
               busy_q <= 1'b0;
            end
            default: begin
               state      <= IDLE;
               rdy_q      <= 1'b0;
               step_ena_q <= '1;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign rdy_      = rdy_q ? 1'b0 : 1'bz;
   assign step_ena_ = step_ena_q;
   assign busy      = busy_q;
   assign fault     = fault_q;

endmodule
